// File: rtl/up_axi_master.sv
// up_axi_master: bridges one-shot up read/write requests onto an
// AXI4-Lite master port, one transaction at a time, with a wait timeout.
module up_axi_master #(
  parameter int AXI_ADDRESS_WIDTH = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                         up_clk,
  input  logic                         up_rst,

  input  logic                         up_wreq,
  input  logic [AXI_ADDRESS_WIDTH-1:0] up_waddr,
  input  logic [31:0]                  up_wdata,
  input  logic [3:0]                   up_wstrb,
  output logic                         up_wack,
  output logic [1:0]                   up_wresp,

  input  logic                         up_rreq,
  input  logic [AXI_ADDRESS_WIDTH-1:0] up_raddr,
  output logic                         up_rack,
  output logic [31:0]                  up_rdata,
  output logic [1:0]                   up_rresp,

  output logic                         up_busy,
  output logic                         up_overrun,

  output logic                         m_axi_awvalid,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                   m_axi_awprot,
  input  logic                         m_axi_awready,

  output logic                         m_axi_wvalid,
  output logic [31:0]                  m_axi_wdata,
  output logic [3:0]                   m_axi_wstrb,
  input  logic                         m_axi_wready,

  input  logic                         m_axi_bvalid,
  input  logic [1:0]                   m_axi_bresp,
  output logic                         m_axi_bready,

  output logic                         m_axi_arvalid,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                   m_axi_arprot,
  input  logic                         m_axi_arready,

  input  logic                         m_axi_rvalid,
  input  logic [31:0]                  m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  output logic                         m_axi_rready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;
  localparam logic [2:0] ACK     = 3'd5;

  localparam logic [16:0] TMO = 17'(TIMEOUT);

  logic [2:0]                   state_q, state_d;
  logic                         awvalid_q, awvalid_d;
  logic                         wvalid_q, wvalid_d;
  logic                         bready_q, bready_d;
  logic                         arvalid_q, arvalid_d;
  logic                         rready_q, rready_d;
  logic [15:0]                  cnt_q, cnt_d;
  logic                         is_rd_q, is_rd_d;
  logic                         pend_q, pend_d;
  logic                         ovr_q, ovr_d;
  logic [1:0]                   wresp_q, wresp_d;
  logic [1:0]                   rresp_q, rresp_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic [AXI_ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_ADDRESS_WIDTH-1:0] araddr_q, araddr_d;
  logic [31:0]                  wdata_q, wdata_d;
  logic [3:0]                   wstrb_q, wstrb_d;

  logic [16:0] cnt_inc;
  logic        tmo;
  logic        aw_ok;
  logic        w_ok;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    is_rd_d   = is_rd_q;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    wresp_d   = wresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    cnt_inc   = {1'b0, cnt_q} + 17'd1;
    tmo       = (cnt_inc == TMO);
    cnt_d     = cnt_inc[15:0];
    aw_ok     = !awvalid_q || m_axi_awready;
    w_ok      = !wvalid_q || m_axi_wready;

    if (state_q != IDLE && (up_wreq || up_rreq))
      ovr_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (up_wreq) begin
          awaddr_d  = up_waddr;
          wdata_d   = up_wdata;
          wstrb_d   = up_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          is_rd_d   = 1'b0;
          state_d   = WR_REQ;
          // a simultaneous read waits behind the write
          if (up_rreq) begin
            araddr_d = up_raddr;
            pend_d   = 1'b1;
          end
        end else if (up_rreq) begin
          araddr_d  = up_raddr;
          arvalid_d = 1'b1;
          is_rd_d   = 1'b1;
          state_d   = RD_REQ;
        end
      end
      WR_REQ: begin
        if (awvalid_q && m_axi_awready)
          awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)
          wvalid_d = 1'b0;
        if (aw_ok && w_ok) begin
          bready_d = 1'b1;
          cnt_d    = '0;
          state_d  = WR_RESP;
        end else if (tmo) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          wresp_d   = 2'b11;
          state_d   = ACK;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid && bready_q) begin
          bready_d = 1'b0;
          wresp_d  = m_axi_bresp;
          state_d  = ACK;
        end else if (tmo) begin
          bready_d = 1'b0;
          wresp_d  = 2'b11;
          state_d  = ACK;
        end
      end
      RD_REQ: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          state_d   = RD_RESP;
        end else if (tmo) begin
          arvalid_d = 1'b0;
          rresp_d   = 2'b11;
          rdata_d   = '0;
          state_d   = ACK;
        end
      end
      RD_RESP: begin
        if (m_axi_rvalid && rready_q) begin
          rready_d = 1'b0;
          rdata_d  = m_axi_rdata;
          rresp_d  = m_axi_rresp;
          state_d  = ACK;
        end else if (tmo) begin
          rready_d = 1'b0;
          rdata_d  = '0;
          rresp_d  = 2'b11;
          state_d  = ACK;
        end
      end
      ACK: begin
        cnt_d = '0;
        if (pend_q) begin
          pend_d    = 1'b0;
          arvalid_d = 1'b1;
          is_rd_d   = 1'b1;
          state_d   = RD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      cnt_q     <= '0;
      is_rd_q   <= 1'b0;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
      wresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      cnt_q     <= cnt_d;
      is_rd_q   <= is_rd_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      wresp_q   <= wresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign up_wack    = (state_q == ACK) && !is_rd_q;
  assign up_rack    = (state_q == ACK) && is_rd_q;
  assign up_wresp   = wresp_q;
  assign up_rresp   = rresp_q;
  assign up_rdata   = rdata_q;
  assign up_busy    = (state_q != IDLE) || pend_q;
  assign up_overrun = ovr_q;

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_up_axi_master.sv
// Directed bench for up_axi_master: zero-wait, stalled, paired,
// timeout, overrun and mid-transaction reset scenarios.
module tb_up_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        wreq, rreq;
  logic [15:0] waddr, raddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wack, rack;
  logic [1:0]  wresp, rresp;
  logic [31:0] rdata;
  logic        busy, ovr;
  logic        awvalid, awready, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  bresp, m_rresp;

  int errs = 0;
  int checks = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  int wack_cnt = 0, rack_cnt = 0;
  int aw0, w0, ar0, wk0, rk0;

  always #5 clk = ~clk;

  up_axi_master #(.AXI_ADDRESS_WIDTH(16), .TIMEOUT(8)) dut (
    .up_clk(clk), .up_rst(rst),
    .up_wreq(wreq), .up_waddr(waddr), .up_wdata(wdata), .up_wstrb(wstrb),
    .up_wack(wack), .up_wresp(wresp),
    .up_rreq(rreq), .up_raddr(raddr),
    .up_rack(rack), .up_rdata(rdata), .up_rresp(rresp),
    .up_busy(busy), .up_overrun(ovr),
    .m_axi_awvalid(awvalid), .m_axi_awaddr(awaddr),
    .m_axi_awprot(awprot), .m_axi_awready(awready),
    .m_axi_wvalid(wvalid), .m_axi_wdata(m_wdata),
    .m_axi_wstrb(m_wstrb), .m_axi_wready(wready),
    .m_axi_bvalid(bvalid), .m_axi_bresp(bresp), .m_axi_bready(bready),
    .m_axi_arvalid(arvalid), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot), .m_axi_arready(arready),
    .m_axi_rvalid(rvalid), .m_axi_rdata(m_rdata),
    .m_axi_rresp(m_rresp), .m_axi_rready(rready)
  );

  always @(posedge clk) begin
    if (awvalid && awready) aw_cnt <= aw_cnt + 1;
    if (wvalid && wready)   w_cnt  <= w_cnt + 1;
    if (arvalid && arready) ar_cnt <= ar_cnt + 1;
    if (wack) wack_cnt <= wack_cnt + 1;
    if (rack) rack_cnt <= rack_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
    wk0 = wack_cnt; rk0 = rack_cnt;
  endtask

  task automatic slave_idle();
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; m_rdata = 0; m_rresp = 0;
  endtask

  initial begin
    rst = 1; wreq = 0; rreq = 0;
    waddr = 0; raddr = 0; wdata = 0; wstrb = 0;
    slave_idle();
    repeat (3) step();
    chk("rst_awvalid", {31'b0, awvalid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ovr", {31'b0, ovr}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_prot", {26'b0, awprot, arprot}, 0);
    rst = 0;
    step();

    // zero-wait write
    snap();
    awready = 1; wready = 1; bvalid = 1; bresp = 0;
    wreq = 1; waddr = 16'h0004; wdata = 32'h11223344; wstrb = 4'hF;
    step();
    wreq = 0;
    chk("w1_awvalid", {31'b0, awvalid}, 1);
    chk("w1_awaddr", {16'b0, awaddr}, 32'h0004);
    chk("w1_wvalid", {31'b0, wvalid}, 1);
    chk("w1_wdata", m_wdata, 32'h11223344);
    chk("w1_wstrb", {28'b0, m_wstrb}, 4'hF);
    step();
    chk("w1_bready", {31'b0, bready}, 1);
    chk("w1_aw_drop", {31'b0, awvalid}, 0);
    step();
    chk("w1_wack", {31'b0, wack}, 1);
    chk("w1_wresp", {30'b0, wresp}, 0);
    step();
    slave_idle();
    chk("w1_wack_end", {31'b0, wack}, 0);
    chk("w1_busy_end", {31'b0, busy}, 0);

    // read with arready delayed, then rvalid delayed
    snap();
    rreq = 1; raddr = 16'h0010;
    step();
    rreq = 0;
    chk("r1_arvalid", {31'b0, arvalid}, 1);
    chk("r1_araddr", {16'b0, araddr}, 32'h0010);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("r1_ar_hold", {31'b0, arvalid}, 1);
      chk("r1_araddr_hold", {16'b0, araddr}, 32'h0010);
    end
    step();
    arready = 1;
    step();
    arready = 0;
    chk("r1_ar_drop", {31'b0, arvalid}, 0);
    chk("r1_rready", {31'b0, rready}, 1);
    step();
    step();
    rvalid = 1; m_rdata = 32'hA5A5_0001; m_rresp = 0;
    step();
    rvalid = 0; m_rdata = 0;
    chk("r1_rack", {31'b0, rack}, 1);
    chk("r1_rdata", rdata, 32'hA5A5_0001);
    chk("r1_rresp", {30'b0, rresp}, 0);
    step();
    chk("r1_rdata_hold", rdata, 32'hA5A5_0001);
    chk("r1_rack_once", rack_cnt - rk0, 1);
    chk("r1_ar_beats", ar_cnt - ar0, 1);

    // W accepted four cycles before AW
    snap();
    wready = 1;
    wreq = 1; waddr = 16'h0008; wdata = 32'hCAFE_F00D; wstrb = 4'h3;
    step();
    wreq = 0;
    step();
    chk("w2_wvalid_drop", {31'b0, wvalid}, 0);
    chk("w2_awvalid_hold", {31'b0, awvalid}, 1);
    wready = 0;
    step();
    step();
    step();
    awready = 1;
    step();
    awready = 0;
    chk("w2_awvalid_drop", {31'b0, awvalid}, 0);
    chk("w2_bready", {31'b0, bready}, 1);
    bvalid = 1; bresp = 2'b01;
    step();
    bvalid = 0; bresp = 0;
    chk("w2_wack", {31'b0, wack}, 1);
    chk("w2_wresp", {30'b0, wresp}, 2'b01);
    step();
    chk("w2_aw_beats", aw_cnt - aw0, 1);
    chk("w2_w_beats", w_cnt - w0, 1);
    chk("w2_wack_once", wack_cnt - wk0, 1);

    // simultaneous write and read
    snap();
    awready = 1; wready = 1; bvalid = 1; arready = 1;
    rvalid = 1; m_rdata = 32'h1234_5678;
    wreq = 1; rreq = 1; waddr = 16'h000C; raddr = 16'h0020;
    wdata = 32'h0BAD_BEEF; wstrb = 4'hF;
    step();
    wreq = 0; rreq = 0;
    chk("p_busy", {31'b0, busy}, 1);
    chk("p_arvalid_w", {31'b0, arvalid}, 0);
    step();
    step();
    chk("p_wack", {31'b0, wack}, 1);
    chk("p_no_ar_yet", {31'b0, arvalid}, 0);
    step();
    chk("p_arvalid", {31'b0, arvalid}, 1);
    chk("p_araddr", {16'b0, araddr}, 32'h0020);
    step();
    step();
    chk("p_rack", {31'b0, rack}, 1);
    chk("p_rdata", rdata, 32'h1234_5678);
    chk("p_ovr", {31'b0, ovr}, 0);
    step();
    slave_idle();
    chk("p_busy_end", {31'b0, busy}, 0);

    // write with bvalid never arriving
    snap();
    awready = 1; wready = 1;
    wreq = 1; waddr = 16'h0100; wdata = 32'h5; wstrb = 4'h1;
    step();
    wreq = 0;
    for (int i = 0; i < 8; i++) step();
    chk("t_bready_last", {31'b0, bready}, 1);
    chk("t_no_wack_yet", {31'b0, wack}, 0);
    step();
    chk("t_wack", {31'b0, wack}, 1);
    chk("t_wresp", {30'b0, wresp}, 2'b11);
    chk("t_bready_drop", {31'b0, bready}, 0);
    step();
    bvalid = 1;
    chk("t_busy", {31'b0, busy}, 0);
    step();
    bvalid = 0;
    step();
    chk("t_late_ignored", wack_cnt - wk0, 1);
    chk("t_bready_stay", {31'b0, bready}, 0);
    slave_idle();

    // overrun during a read, then reset mid-read
    snap();
    rreq = 1; raddr = 16'h0030;
    step();
    rreq = 0;
    step();
    rreq = 1; raddr = 16'h0040;
    step();
    rreq = 0;
    chk("o_ovr", {31'b0, ovr}, 1);
    chk("o_araddr", {16'b0, araddr}, 32'h0030);
    chk("o_arvalid", {31'b0, arvalid}, 1);
    rst = 1;
    step();
    chk("o_rst_arvalid", {31'b0, arvalid}, 0);
    chk("o_rst_busy", {31'b0, busy}, 0);
    chk("o_rst_ovr", {31'b0, ovr}, 0);
    chk("o_rst_rdata", rdata, 0);
    chk("o_rst_rack", {31'b0, rack}, 0);
    rst = 0;
    arready = 1; rvalid = 1; m_rdata = 32'hDEAD_0000;
    repeat (4) step();
    chk("o_no_rack", rack_cnt - rk0, 0);
    chk("o_no_ar", ar_cnt - ar0, 0);
    slave_idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/up_axi_master.md
UP_AXI_MASTER -- requirements
Module: up_axi_master

Interface
REQ-001 SHALL have parameter AXI_ADDRESS_WIDTH, default 16, the width of the AXI and up byte addresses.
REQ-002 SHALL have parameter TIMEOUT, default 1023, the maximum number of wait cycles per transaction (range 1..65535).
REQ-003 SHALL have port up_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port up_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports up_wreq (in, 1), up_waddr (in, AXI_ADDRESS_WIDTH), up_wdata (in, 32) and up_wstrb (in, 4): a one-cycle write request pulse with its operands.
REQ-006 SHALL have ports up_wack (out, 1) and up_wresp (out, 2): the write completion pulse and its response code.
REQ-007 SHALL have ports up_rreq (in, 1) and up_raddr (in, AXI_ADDRESS_WIDTH): a one-cycle read request pulse and its address.
REQ-008 SHALL have ports up_rack (out, 1), up_rdata (out, 32) and up_rresp (out, 2): the read completion pulse, its data and its response code.
REQ-009 SHALL have ports up_busy (out, 1), meaning a transaction is in flight, and up_overrun (out, 1), a sticky flag meaning a request was dropped.
REQ-010 SHALL have AXI4-Lite master ports m_axi_awvalid/awaddr/awprot/awready, m_axi_wvalid/wdata/wstrb/wready, m_axi_bvalid/bresp/bready, m_axi_arvalid/araddr/arprot/arready and m_axi_rvalid/rdata/rresp/rready, with standard AXI4-Lite directions and widths.

Function
REQ-011 SHALL implement the FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and ACK.
REQ-012 SHALL, in IDLE with up_wreq=1, register the write address, data and strobe, then enter WR_REQ, asserting m_axi_awvalid and m_axi_wvalid from the next cycle.
REQ-013 SHALL, in WR_REQ, deassert awvalid in the cycle after awvalid&awready is sampled, and deassert wvalid independently in the cycle after wvalid&wready; once both handshakes are done, enter WR_RESP with bready=1.
REQ-014 SHALL, on bvalid&bready, capture bresp, drop bready and enter ACK; ACK pulses up_wack=1 for exactly one cycle with up_wresp=the captured bresp, then returns to IDLE.
REQ-015 SHALL, in IDLE with up_rreq=1, register the read address, then enter RD_REQ with arvalid=1; on arvalid&arready, drop arvalid and enter RD_RESP with rready=1.
REQ-016 SHALL, on rvalid&rready, capture rdata and rresp, then pulse up_rack for one cycle with up_rdata and up_rresp valid; up_rdata SHALL hold its value until the next read completes.
REQ-017 SHALL give a minimum latency of 3 cycles from request to ack when the slave is zero-wait (request at cycle 0, valid at cycle 1, response at cycle 2, ack at cycle 3).
REQ-018 SHALL, when up_wreq and up_rreq coincide in IDLE, serve the write first, latch the read as pending, and issue the pending read in the cycle after the write's ACK.
REQ-019 SHALL, for requests arriving outside IDLE (other than the pending read of REQ-018), drop the request without any ack and set up_overrun=1 until reset.
REQ-020 SHALL assert up_busy=1 in every state except IDLE, and also while a pending read exists.
REQ-021 SHALL hold AXI payloads stable while the corresponding valid is high, and SHALL never deassert a valid before its handshake, except on timeout.
REQ-022 SHALL reset a 16-bit wait counter on entry to each of WR_REQ/WR_RESP/RD_REQ/RD_RESP, and increment it every cycle spent there.
REQ-023 SHALL abort when the counter reaches TIMEOUT: drop all valids and readies, pulse the matching ack with resp=2'b11, set up_rdata=0 for reads, and return to IDLE; any late slave response SHALL be ignored.
REQ-024 SHALL drive m_axi_awprot=m_axi_arprot=3'b000.

Reset
REQ-025 SHALL, while up_rst=1, go to IDLE and drive all m_axi valids/readies=0, up_wack=up_rack=0, up_wresp=up_rresp=0, up_rdata=0, up_busy=0 and up_overrun=0, and clear the pending read.
REQ-026 SHALL, on reset mid-transaction, abandon that transaction with no ack generated.

Verification
REQ-027 Zero-wait write: waddr=0x0004, wdata=0x11223344, wstrb=0xF, slave ready at once, bresp=0 -> awaddr=0x0004 and wdata seen at cycle 1; up_wack at cycle 3 with up_wresp=0.
REQ-028 Read with arready delayed 5 cycles and rvalid after another 2 cycles, rdata=0xA5A5_0001, rresp=0 -> a single up_rack with up_rdata=0xA5A5_0001; arvalid stays high and araddr stays stable until the handshake.
REQ-029 Write with wready 4 cycles before awready -> wvalid drops after its own handshake; exactly one AW and one W beat; one up_wack.
REQ-030 up_wreq and up_rreq in the same cycle -> write completes first, the read issues the cycle after up_wack, then up_rack; up_overrun stays 0.
REQ-031 Slave never asserts bvalid, TIMEOUT=8 -> up_wack with up_wresp=2'b11 after 8 WR_RESP cycles; bready=0 afterwards; up_busy=0.
REQ-032 up_rreq while busy -> no extra AXI traffic and up_overrun=1; up_rst mid-read -> all outputs reach reset values and no up_rack is produced.
